ahb_slave_mem: RTL

- AHB-Lite subordinate with a word-organised register-array memory.
- Responds to the hsel strobe generated by the system address decoder and completes data phases on the shared bus.
- Supports byte, halfword and word accesses, programmable wait states, and a two-cycle ERROR response.
- One instance sits behind each decoder select line.

---
 rtl/ahb_slave_mem.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-Lite subordinate backed by a word-organised register array.
// Supports byte/halfword/word accesses, fixed wait states and a two-cycle ERROR response.
module ahb_slave_mem #(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hready,
    output logic [31:0]       hrdata,
    output logic              hreadyout,
    output logic              hresp
);

    // state | meaning
    // IDLE  | no data phase, or zero-wait completion cycle when pend_q is set
    // WAIT  | OKAY transfer stalled, wait_cnt cycles of hreadyout low remain
    // DONE  | completion cycle after wait states
    // ERR1  | first ERROR cycle (hreadyout low)
    // ERR2  | second ERROR cycle (hreadyout high), may accept next address
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam int IDX_W = $clog2(DEPTH);

    state_t           state;
    logic [3:0]       wait_cnt;
    logic [IDX_W+1:0] addr_q;
    logic             write_q;
    logic [1:0]       size_q;
    logic             pend_q;

    logic [31:0]      mem [DEPTH];

    logic             accept;
    logic             addr_oob;
    logic             bad;
    logic             complete;
    logic [IDX_W-1:0] widx;
    logic [3:0]       lane_en;

    assign accept   = hsel & hready & htrans[1];
    assign addr_oob = 32'(haddr) >= 32'(DEPTH * 4);
    assign bad      = addr_oob
                    | (hsize > 3'b010)
                    | ((hsize == 3'b001) & haddr[0])
                    | ((hsize == 3'b010) & (haddr[1:0] != 2'b00));

    // pend_q marks a good transfer; it completes on any cycle where we drive ready
    assign complete = pend_q & hreadyout;
    assign widx     = addr_q[IDX_W+1:2];
    assign hrdata   = complete ? mem[widx] : 32'h0;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
            pend_q    <= 1'b0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state     <= ST_DONE;
                        hreadyout <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    pend_q    <= 1'b0;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    if (accept) begin
                        addr_q  <= haddr[IDX_W+1:0];
                        write_q <= hwrite;
                        size_q  <= hsize[1:0];
                        if (bad) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                        end else begin
                            pend_q <= 1'b1;
                            if (WAIT_STATES != 0) begin
                                state     <= ST_WAIT;
                                wait_cnt  <= 4'(WAIT_STATES);
                                hreadyout <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        lane_en = 4'b0000;
        case (size_q)
            2'b00:   lane_en[addr_q[1:0]] = 1'b1;
            2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Array is not reset; a reset on the completion edge suppresses the write
    always_ff @(posedge hclk) begin
        if (!hreset && complete && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[widx][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule
